lsu_mem_stage: RTL
==================

# lsu_mem_stage

Load/store unit sitting directly downstream of the ALU in the execute-to-memory path. It takes the ALU result as the effective address and performs one RISC-V byte, halfword or word access against the data memory per request. Memory uses a req/ack handshake. Store data is byte-lane aligned and load data is sign- or zero-extended for writeback. Misaligned, illegal and timed-out accesses are reported instead of being issued or completed silently.

## Interface
Parameters:
- WIDTH, 32, data and address width; only 32 is supported.
- TIMEOUT, 255, maximum number of cycles to wait for mem_ack after mem_req rises; must be ≥1 and fit in 8 bits.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset; the block is in reset while low.
- start  input  1  request strobe; sampled only in IDLE.
- is_store  input  1  1 = store, 0 = load.
- funct3  input  3  access type. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW. All other codes are illegal.
- addr  input  WIDTH  effective address (ALU result).
- wdata  input  WIDTH  store data (rs2); only the low byte/halfword is used for SB/SH.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  qualifies done; the access faulted.
- err_code  output  2  01 misaligned, 10 illegal funct3, 11 timeout; valid with done/err, otherwise 00.
- rdata  output  WIDTH  extended load result; holds until the next load completes.
- mem_req  output  1  memory request.
- mem_we  output  1  write enable.
- mem_addr  output  WIDTH  word address: {addr[31:2], 2'b00}.
- mem_wdata  output  WIDTH  lane-replicated store data.
- mem_wstrb  output  4  byte enables; 0000 for loads.
- mem_ack  input  1  memory completion; for loads, mem_rdata is valid in the same cycle.
- mem_rdata  input  WIDTH  read word.

## Operation
- States: IDLE, REQ, RESP, FAULT.
- Transitions out of IDLE when start=1:
  - illegal funct3 → FAULT (err_code 10).
  - Otherwise misaligned → FAULT (err_code 01). Misaligned means halfword with addr[0]=1, or word with addr[1:0]≠00.
  - Otherwise → REQ. addr, funct3, is_store and the store data are latched here.
- Illegal funct3 takes priority over misalignment.
- REQ:
  - mem_req=1; mem_addr, mem_we, mem_wdata and mem_wstrb come from the latched values and are held stable until ack.
  - A down-counter is loaded with TIMEOUT on entry.
  - On mem_ack=1: the load word is captured and the state moves to RESP.
  - If the counter reaches 0 with no ack: → FAULT (err_code 11) and mem_req drops.
- RESP: done=1 for one cycle; rdata is updated on loads only. Next state is IDLE.
- FAULT: done=1 and err=1 for one cycle. No memory access is issued and rdata is unchanged. Next state is IDLE.
- Store lane rules:
  - SB: wdata[7:0] replicated to all 4 bytes; strobe = 0001 << addr[1:0].
  - SH: wdata[15:0] replicated to both halves; strobe = 0011 << addr[1:0].
  - SW: strobe = 1111.
- Load extraction:
  - Select the byte or half by the latched addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- start while busy is ignored; there is no queueing.
- mem_ack outside REQ is ignored.

## Timing
- Reset values: state IDLE; busy, done, err, mem_req, mem_we = 0; err_code = 00; mem_wstrb = 0000; rdata, mem_addr, mem_wdata = 0.
- All outputs are registered or decoded from state only. There is no combinational path from start or mem_ack to any output.
- Minimum latency: start at edge E0 → mem_req high from E0 → ack seen at E1 → done high from E1 to E2. That is 2 cycles from start to done.
- Fault latency: done/err high for the single cycle following the start edge.
- Timeout: with no ack, mem_req stays high for exactly TIMEOUT cycles, then a FAULT pulse follows.
- An ack arriving in the same cycle the counter reaches 0 counts as success.
- Reset asserted mid-access: all outputs clear immediately (asynchronously), the access is abandoned, and no done pulse is produced.
- Back-to-back operation: a new start is accepted in the cycle IDLE is re-entered, i.e. the cycle after the done pulse.

## Test plan
- SW at addr 0x100, wdata 0xDEADBEEF, ack in the first REQ cycle → mem_addr 0x100, mem_wstrb 1111, mem_wdata 0xDEADBEEF, done 2 cycles after start, err 0.
- SB at addr 0x103, wdata 0x000000A5 → mem_wdata 0xA5A5A5A5, mem_wstrb 1000, mem_addr 0x100.
- LB at addr 0x102, mem_rdata 0x12F43456 → rdata 0xFFFFFFF4. LBU with the same inputs → 0x000000F4. LHU at addr 0x102 → 0x000012F4.
- LW at addr 0x106 → err_code 01 one cycle after start, mem_req never asserted. funct3 011 (any address) → err_code 10.
- TIMEOUT=4, load with no ack → mem_req high for exactly 4 cycles, then done=1, err=1, err_code 11. rdata unchanged.
- reset driven low during REQ with ack pending → mem_req and busy are 0 immediately. After reset releases: IDLE, no done pulse. A start pulse during busy is never acted on.

Source files
------------

// File: rtl/lsu_mem_stage_if.sv
// Data-memory bus between the load/store unit and the data memory.
// The LSU drives the request side and the memory returns ack/read data.
interface lsu_mem_stage_if #(
    parameter int WIDTH = 32
);
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [3:0]       mem_wstrb;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// RISC-V byte/half/word load-store stage with a req/ack data-memory port.
// Faults (misaligned, illegal funct3, ack timeout) end in an err-qualified done pulse.
module lsu_mem_stage #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_store,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [WIDTH-1:0] rdata,
    lsu_mem_stage_if.master  mem
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, FAULT} state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t           state_q, state_d;
    logic [1:0]       code_q, code_d;
    logic [7:0]       cnt_q;
    logic [WIDTH-1:0] addr_q, wdata_q, rdata_q;
    logic [3:0]       strb_q;
    logic [2:0]       funct3_q;
    logic             store_q;

    logic             illegal, misaligned;
    logic [WIDTH-1:0] lane_data;
    logic [3:0]       lane_strb;
    logic [7:0]       load_byte;
    logic [15:0]      load_half;
    logic [WIDTH-1:0] load_ext;

    // Request decode; illegal codes win over misalignment in the FSM below.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        illegal = 1'b1;
        case (funct3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = is_store;
            default:                illegal = 1'b1;
        endcase
        misaligned = (funct3[1:0] == 2'b01 && addr[0]) ||
                     (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    end

    always_comb begin
        lane_data = wdata;
        lane_strb = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                lane_data = {4{wdata[7:0]}};
                lane_strb = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                lane_data = {2{wdata[15:0]}};
                lane_strb = 4'b0011 << addr[1:0];
            end
            default: ;
        endcase
        if (!is_store) lane_strb = 4'b0000;
    end

    // Load extraction works from the latched address, not the live input.
    always_comb begin
        load_byte = mem.mem_rdata[7:0];
        case (addr_q[1:0])
            2'b00: load_byte = mem.mem_rdata[7:0];
            2'b01: load_byte = mem.mem_rdata[15:8];
            2'b10: load_byte = mem.mem_rdata[23:16];
            2'b11: load_byte = mem.mem_rdata[31:24];
            default: ;
        endcase
        load_half = addr_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        load_ext  = mem.mem_rdata;
        case (funct3_q)
            3'b000:  load_ext = {{(WIDTH-8){load_byte[7]}}, load_byte};
            3'b001:  load_ext = {{(WIDTH-16){load_half[15]}}, load_half};
            3'b100:  load_ext = {{(WIDTH-8){1'b0}}, load_byte};
            3'b101:  load_ext = {{(WIDTH-16){1'b0}}, load_half};
            default: load_ext = mem.mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            IDLE: if (start) begin
                if (illegal) begin
                    state_d = FAULT;
                    code_d  = 2'b10;
                end else if (misaligned) begin
                    state_d = FAULT;
                    code_d  = 2'b01;
                end else begin
                    state_d = REQ;
                end
            end
            // Ack on the last counted cycle still counts as success.
            REQ: if (mem.mem_ack) begin
                state_d = RESP;
            end else if (cnt_q == 8'd1) begin
                state_d = FAULT;
                code_d  = 2'b11;
            end
            RESP, FAULT: state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state_q <= IDLE;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= 8'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            strb_q   <= 4'b0000;
            funct3_q <= 3'b000;
            store_q  <= 1'b0;
        end else if (state_q == IDLE && state_d == REQ) begin
            cnt_q    <= TIMEOUT_C;
            addr_q   <= addr;
            wdata_q  <= lane_data;
            strb_q   <= lane_strb;
            funct3_q <= funct3;
            store_q  <= is_store;
        end else if (state_q == REQ) begin
            if (mem.mem_ack) begin
                if (!store_q) rdata_q <= load_ext;
            end else begin
                cnt_q <= cnt_q - 8'd1;
            end
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == RESP) || (state_q == FAULT);
    assign err      = (state_q == FAULT);
    assign err_code = (state_q == FAULT) ? code_q : 2'b00;
    assign rdata    = rdata_q;

    assign mem.mem_req   = (state_q == REQ);
    assign mem.mem_we    = (state_q == REQ) && store_q;
    assign mem.mem_addr  = {addr_q[WIDTH-1:2], 2'b00};
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_wstrb = (state_q == REQ) ? strb_q : 4'b0000;
endmodule
